matmul_result_stream: RTL

Downstream stage of the 2x2 matrix-multiply core. It captures the 2x2 signed result matrix C whenever the core pulses done, and buffers up to two result matrices. It serialises them row-major (C00, C01, C10, C11) onto an AXI-Stream master with optional saturation to a narrower output width. It backpressures the core through in_ready and flags dropped results.

---
 rtl/matmul_result_stream_if.sv | 25 ++
 rtl/matmul_result_stream.sv | 115 +++++++++++
 2 files changed

// File: rtl/matmul_result_stream_if.sv
// Capture-side and AXI-Stream-side signals of the matmul result streamer.
interface matmul_result_stream_if #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 16
);
   logic                                 done_in;
   logic [1:0][1:0][ACC_W-1:0]           c_in;
   logic                                 in_ready;
   logic signed [OUT_W-1:0]              m_tdata;
   logic                                 m_tvalid;
   logic                                 m_tready;
   logic                                 m_tlast;

   // Streamer side: accepts matrices, drives the stream
   modport master (
      input  done_in, c_in, m_tready,
      output in_ready, m_tdata, m_tvalid, m_tlast
   );

   // Core/sink side: supplies matrices, consumes the stream
   modport slave (
      output done_in, c_in, m_tready,
      input  in_ready, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/matmul_result_stream.sv
// Buffers up to two 2x2 result matrices from the matmul core and streams them
// row-major (C00, C01, C10, C11) with optional saturation to OUT_W bits.
module matmul_result_stream #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SAT   = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   matmul_result_stream_if.master bus,
   output logic                 overflow,
   output logic [CNT_W-1:0]     frame_cnt
);
   typedef logic signed [ACC_W-1:0] acc_t;

   // Largest/smallest value representable in OUT_W signed bits, at ACC_W width
   localparam acc_t SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam acc_t SAT_MIN = ~SAT_MAX;

   acc_t                 slot_q [2][4];
   logic [1:0]           count_q, count_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           idx_q, idx_d;
   logic                 overflow_d;
   logic [CNT_W-1:0]     frame_d;
   logic                 tvalid_q, tvalid_d;
   logic                 tlast_q, tlast_d;
   logic [OUT_W-1:0]     tdata_q, tdata_d;
   logic                 in_ready_q, in_ready_d;
   logic                 wr_en, xfer, pop;
   acc_t                 elem_d;

   // Saturate or truncate one accumulator element to the stream width
   function automatic logic [OUT_W-1:0] conv(input acc_t v);
      if (SAT != 0 && v > SAT_MAX) return OUT_W'(SAT_MAX);
      if (SAT != 0 && v < SAT_MIN) return OUT_W'(SAT_MIN);
      return OUT_W'(v);
   endfunction

   // Next-state and next-output computation from registered state
   always_comb begin
      wr_en      = bus.done_in && in_ready_q;
      xfer       = tvalid_q && bus.m_tready;
      pop        = xfer && (idx_q == 2'd3);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      idx_d      = idx_q;
      frame_d    = frame_cnt;
      overflow_d = overflow || (bus.done_in && !in_ready_q);
      if (wr_en) wr_ptr_d = ~wr_ptr_q;
      if (xfer)  idx_d = idx_q + 2'd1;
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
         frame_d  = frame_cnt + CNT_W'(1);
      end
      count_d = count_q + 2'(wr_en) - 2'(pop);
      // A matrix written this edge into the slot about to be read is not yet in slot_q
      if (wr_en && (wr_ptr_q == rd_ptr_d))
         elem_d = bus.c_in[idx_d[1]][idx_d[0]];
      else
         elem_d = slot_q[rd_ptr_d][idx_d];
      tvalid_d   = (count_d != 2'd0);
      tlast_d    = tvalid_d && (idx_d == 2'd3);
      tdata_d    = tvalid_d ? conv(elem_d) : '0;
      in_ready_d = (count_d < 2'd2);
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         idx_q      <= '0;
         overflow   <= 1'b0;
         frame_cnt  <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         idx_q      <= idx_d;
         overflow   <= overflow_d;
         frame_cnt  <= frame_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tdata_q    <= tdata_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Matrix slot storage, written on accepted captures
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 2; s++)
            for (int e = 0; e < 4; e++)
               slot_q[s][e] <= '0;
      end else if (wr_en) begin
         slot_q[wr_ptr_q][0] <= bus.c_in[0][0];
         slot_q[wr_ptr_q][1] <= bus.c_in[0][1];
         slot_q[wr_ptr_q][2] <= bus.c_in[1][0];
         slot_q[wr_ptr_q][3] <= bus.c_in[1][1];
      end
   end

   assign bus.m_tvalid = tvalid_q;
   assign bus.m_tlast  = tlast_q;
   assign bus.m_tdata  = tdata_q;
   assign bus.in_ready = in_ready_q;
endmodule
